// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch (IF) and
//   load/store (MEM). MEM accesses have fixed priority over fetch, but a fetch
//   already in flight always completes first. Each access is a req/ack
//   handshake of variable latency. The fetched instruction is buffered until
//   the pipeline consumes it. The two stall outputs are ORed by the pipeline
//   with the hazard unit's stalls.
//
// Ports
//   CLK, reset                  clock, synchronous active-high reset
//   IF_Req/IF_Addr/IF_Flush     fetch request, PC, taken-branch flush
//   MEM_Req/MEM_Write/MEM_Addr/MEM_WData
//                               load/store request from the MEM stage
//   Mem_Req/Mem_Write/Mem_Addr/Mem_WData
//                               registered request to memory, stable until ack
//   Mem_RData/Mem_Ack           memory read data and completion
//   IF_Inst/IF_Valid            buffered instruction, level valid until consumed
//   MEM_RData/MEM_Done          load result, one-cycle completion pulse
//   Stall_Pipe/Stall_Fetch      combinational pipeline stalls
//   Timeout_Err                 sticky watchdog flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  IF_Req,
  input  logic [ADDR_WIDTH-1:0] IF_Addr,
  input  logic                  IF_Flush,
  input  logic                  MEM_Req,
  input  logic                  MEM_Write,
  input  logic [ADDR_WIDTH-1:0] MEM_Addr,
  input  logic [DATA_WIDTH-1:0] MEM_WData,
  output logic                  Mem_Req,
  output logic                  Mem_Write,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_WData,
  input  logic [DATA_WIDTH-1:0] Mem_RData,
  input  logic                  Mem_Ack,
  output logic [DATA_WIDTH-1:0] IF_Inst,
  output logic                  IF_Valid,
  output logic [DATA_WIDTH-1:0] MEM_RData,
  output logic                  MEM_Done,
  output logic                  Stall_Pipe,
  output logic                  Stall_Fetch,
  output logic                  Timeout_Err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  mem_done_q, mem_done_d;
  logic                  timeout_q, timeout_d;
  logic                  drop_q, drop_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  stall_pipe;

  // Watchdog count saturates at the threshold instead of wrapping.
  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + WD_W'(1);
  endfunction

  // MEM_Done marks the cycle in which the MEM stage is released; its inputs
  // still describe the completed access, so it is not re-granted then.
  assign stall_pipe  = MEM_Req & ~mem_done_q;
  assign Stall_Pipe  = stall_pipe;
  assign Stall_Fetch = IF_Req & ~if_valid_q & ~stall_pipe;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    timeout_d   = timeout_q;
    drop_d      = drop_q;
    wdog_d      = wdog_q;

    // Buffered instruction leaves on consumption; a flush wins either way.
    if (IF_Flush || (if_valid_q && !stall_pipe)) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (MEM_Req && !mem_done_q) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_write_d = MEM_Write;
          mem_addr_d  = MEM_Addr;
          mem_wdata_d = MEM_WData;
        end else if (IF_Req && !if_valid_q && !IF_Flush) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = IF_Addr;
        end
      end
      DATA: begin
        if (Mem_Ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          if (!mem_write_q) begin
            mem_rdata_d = Mem_RData;
          end
        end
      end
      FETCH: begin
        if (Mem_Ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A flush earlier in the access, or in this very cycle, makes the
          // returned word stale.
          if (!drop_q && !IF_Flush) begin
            if_inst_d  = Mem_RData;
            if_valid_d = 1'b1;
          end
        end else if (IF_Flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (state_q == IDLE || Mem_Ack) begin
      wdog_d = '0;
    end else if (mem_req_q) begin
      wdog_d = sat_inc(wdog_q);
    end
    if (wdog_d == WD_MAX) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
      drop_q      <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      timeout_q   <= timeout_d;
      drop_q      <= drop_d;
      wdog_q      <= wdog_d;
    end
  end

  assign Mem_Req     = mem_req_q;
  assign Mem_Write   = mem_write_q;
  assign Mem_Addr    = mem_addr_q;
  assign Mem_WData   = mem_wdata_q;
  assign IF_Inst     = if_inst_q;
  assign IF_Valid    = if_valid_q;
  assign MEM_RData   = mem_rdata_q;
  assign MEM_Done    = mem_done_q;
  assign Timeout_Err = timeout_q;

endmodule
